// File: rtl/lcd_bitmap_window_show.sv
// lcd_bitmap_window_show
// Renders a 1-bit-per-pixel bitmap from ROM into an 8080-style LCD write path
// (ST7789/ILI9341 command set, RGB565). On a start pulse it latches the window
// origin and colours, sends the 0x2A/0x2B/0x2C window sequence, then streams
// one ROM row per LCD row, expanding every bit into two colour bytes.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   show_pic_flag        start pulse, honoured only in IDLE
//   x_start, y_start     window origin, latched at start
//   fg_color, bg_color   RGB565 colours for bit=1 / bit=0, latched at start
//   wr_done              writer consumed the current word
//   rom_addr, rom_q      registered row address / row bitmap (ROM_LAT clocks)
//   show_pic_data        {1'b0,cmd} or {1'b1,data}, registered
//   en_write_show_pic    show_pic_data is valid for the writer
//   show_pic_done        one-cycle completion pulse
//   busy                 high in every state except IDLE
//
// Build option: define LCD_BITMAP_MSB_FIRST_EN to emit column 0 from
// rom_q[PIC_W-1] (left shift); otherwise column 0 comes from rom_q[0].

module lcd_bitmap_window_show #(
  parameter int unsigned PIC_W    = 240,
  parameter int unsigned PIC_H    = 320,
  parameter int unsigned ROM_AW   = 9,
  parameter int unsigned ROM_BASE = 0,
  parameter int unsigned ROM_LAT  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              show_pic_flag,
  input  logic [8:0]        x_start,
  input  logic [8:0]        y_start,
  input  logic [15:0]       fg_color,
  input  logic [15:0]       bg_color,
  input  logic              wr_done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIC_W-1:0]  rom_q,
  output logic [8:0]        show_pic_data,
  output logic              en_write_show_pic,
  output logic              show_pic_done,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StSetWin, StFetch, StPixel, StDone} state_t;

  localparam logic [15:0]       WOff     = 16'(PIC_W - 1);
  localparam logic [15:0]       HOff     = 16'(PIC_H - 1);
  localparam logic [8:0]        LastCol  = 9'(PIC_W - 1);
  localparam logic [8:0]        LastRow  = 9'(PIC_H - 1);
  localparam logic [7:0]        LatLast  = 8'(ROM_LAT);
  localparam logic [ROM_AW-1:0] BaseAddr = ROM_AW'(ROM_BASE);

  state_t           state;
  logic [8:0]       xs_q, ys_q;
  logic [15:0]      fg_q, bg_q;
  logic [3:0]       widx;
  logic [8:0]       row, col;
  logic             byte_sel;
  logic [7:0]       lat_cnt;
  logic [PIC_W-1:0] row_sr;

  logic [15:0]      xs16, xe16, ys16, ye16;
  logic [3:0]       widx_next;
  logic [8:0]       win_next;
  logic [8:0]       row_next;
  logic [PIC_W-1:0] sr_shift;
  logic             cap_bit, cur_bit, next_bit;
  logic [15:0]      cap_color, cur_color, next_color;

  always_comb begin
    xs16      = {7'd0, xs_q};
    ys16      = {7'd0, ys_q};
    xe16      = xs16 + WOff;
    ye16      = ys16 + HOff;
    widx_next = widx + 4'd1;
    row_next  = row + 9'd1;

    win_next = 9'h000;
    case (widx_next)
      4'd0:    win_next = 9'h02A;
      4'd1:    win_next = {1'b1, xs16[15:8]};
      4'd2:    win_next = {1'b1, xs16[7:0]};
      4'd3:    win_next = {1'b1, xe16[15:8]};
      4'd4:    win_next = {1'b1, xe16[7:0]};
      4'd5:    win_next = 9'h02B;
      4'd6:    win_next = {1'b1, ys16[15:8]};
      4'd7:    win_next = {1'b1, ys16[7:0]};
      4'd8:    win_next = {1'b1, ye16[15:8]};
      4'd9:    win_next = {1'b1, ye16[7:0]};
      4'd10:   win_next = 9'h02C;
      default: win_next = 9'h000;
    endcase

`ifdef LCD_BITMAP_MSB_FIRST_EN
    sr_shift = row_sr << 1;
    cap_bit  = rom_q[PIC_W-1];
    cur_bit  = row_sr[PIC_W-1];
    next_bit = sr_shift[PIC_W-1];
`else
    sr_shift = row_sr >> 1;
    cap_bit  = rom_q[0];
    cur_bit  = row_sr[0];
    next_bit = sr_shift[0];
`endif

    cap_color  = cap_bit  ? fg_q : bg_q;
    cur_color  = cur_bit  ? fg_q : bg_q;
    next_color = next_bit ? fg_q : bg_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= StIdle;
      xs_q              <= '0;
      ys_q              <= '0;
      fg_q              <= '0;
      bg_q              <= '0;
      widx              <= '0;
      row               <= '0;
      col               <= '0;
      byte_sel          <= 1'b0;
      lat_cnt           <= '0;
      row_sr            <= '0;
      rom_addr          <= '0;
      show_pic_data     <= '0;
      en_write_show_pic <= 1'b0;
      show_pic_done     <= 1'b0;
      busy              <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (show_pic_flag) begin
            xs_q              <= x_start;
            ys_q              <= y_start;
            fg_q              <= fg_color;
            bg_q              <= bg_color;
            widx              <= '0;
            row               <= '0;
            show_pic_data     <= 9'h02A;
            en_write_show_pic <= 1'b1;
            busy              <= 1'b1;
            state             <= StSetWin;
          end
        end
        StSetWin: begin
          if (wr_done) begin
            if (widx == 4'd10) begin
              en_write_show_pic <= 1'b0;
              rom_addr          <= BaseAddr + ROM_AW'(row);
              lat_cnt           <= '0;
              state             <= StFetch;
            end else begin
              widx          <= widx_next;
              show_pic_data <= win_next;
            end
          end
        end
        StFetch: begin
          // rom_q is valid in the (ROM_LAT+1)th cycle after rom_addr moved
          if (lat_cnt == LatLast) begin
            row_sr            <= rom_q;
            col               <= '0;
            byte_sel          <= 1'b0;
            show_pic_data     <= {1'b1, cap_color[15:8]};
            en_write_show_pic <= 1'b1;
            state             <= StPixel;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        StPixel: begin
          if (wr_done) begin
            if (!byte_sel) begin
              byte_sel      <= 1'b1;
              show_pic_data <= {1'b1, cur_color[7:0]};
            end else if (col == LastCol) begin
              en_write_show_pic <= 1'b0;
              if (row == LastRow) begin
                show_pic_done <= 1'b1;
                state         <= StDone;
              end else begin
                row      <= row_next;
                rom_addr <= BaseAddr + ROM_AW'(row_next);
                lat_cnt  <= '0;
                state    <= StFetch;
              end
            end else begin
              col           <= col + 9'd1;
              byte_sel      <= 1'b0;
              row_sr        <= sr_shift;
              show_pic_data <= {1'b1, next_color[15:8]};
            end
          end
        end
        StDone: begin
          show_pic_done <= 1'b0;
          busy          <= 1'b0;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bitmap_window_show.sv
// Directed bench for lcd_bitmap_window_show: PIC_W=4, PIC_H=2, ROM_BASE=5,
// ROM_LAT=3, with a pipelined ROM model and a writer that pulses wr_done.
module tb_lcd_bitmap_window_show;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        show_pic_flag;
  logic [8:0]  x_start, y_start;
  logic [15:0] fg_color, bg_color;
  logic        wr_done;
  logic [8:0]  rom_addr;
  logic [3:0]  rom_q;
  logic [8:0]  show_pic_data;
  logic        en_write_show_pic;
  logic        show_pic_done;
  logic        busy;

  int passes = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_bitmap_window_show #(
    .PIC_W(4), .PIC_H(2), .ROM_AW(9), .ROM_BASE(5), .ROM_LAT(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .show_pic_flag(show_pic_flag),
    .x_start(x_start), .y_start(y_start), .fg_color(fg_color), .bg_color(bg_color),
    .wr_done(wr_done), .rom_addr(rom_addr), .rom_q(rom_q),
    .show_pic_data(show_pic_data), .en_write_show_pic(en_write_show_pic),
    .show_pic_done(show_pic_done), .busy(busy)
  );

  // ROM with three clocks of latency; unmapped rows read all-ones
  logic [8:0] a_p0, a_p1, a_p2;
  always @(posedge sys_clk) begin
    a_p0 <= rom_addr;
    a_p1 <= a_p0;
    a_p2 <= a_p1;
  end
  always_comb begin
    rom_q = 4'b1111;
    if (a_p2 == 9'd5) rom_q = 4'b0101;
    else if (a_p2 == 9'd6) rom_q = 4'b1000;
  end

  logic [8:0] win1 [0:10] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10D,
                              9'h02B, 9'h101, 9'h12C, 9'h101, 9'h12D, 9'h02C};
  logic [8:0] win2 [0:10] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                              9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
`ifdef LCD_BITMAP_MSB_FIRST_EN
  logic [8:0] pix_r0 [0:7] = '{9'h100, 9'h11F, 9'h1F8, 9'h100,
                               9'h100, 9'h11F, 9'h1F8, 9'h100};
  logic [8:0] pix_r1 [0:7] = '{9'h1F8, 9'h100, 9'h100, 9'h11F,
                               9'h100, 9'h11F, 9'h100, 9'h11F};
  logic [8:0] pix_f2 [0:2] = '{9'h1FF, 9'h1FF, 9'h107};
`else
  logic [8:0] pix_r0 [0:7] = '{9'h1F8, 9'h100, 9'h100, 9'h11F,
                               9'h1F8, 9'h100, 9'h100, 9'h11F};
  logic [8:0] pix_r1 [0:7] = '{9'h100, 9'h11F, 9'h100, 9'h11F,
                               9'h100, 9'h11F, 9'h1F8, 9'h100};
  logic [8:0] pix_f2 [0:2] = '{9'h107, 9'h1E0, 9'h1FF};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Writer: wait for a valid word, hold it gap cycles, check it, pulse wr_done
  task automatic consume(input int gap, input string tag, input logic [8:0] exp);
    int n = 0;
    while (en_write_show_pic !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (en_write_show_pic !== 1'b1) begin
      check({tag, "_en_timeout"}, 32'(en_write_show_pic), 32'd1);
      return;
    end
    repeat (gap - 1) tick();
    check(tag, 32'(show_pic_data), 32'(exp));
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic count_fetch(input string tag);
    int n = 0;
    while (en_write_show_pic === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    check(tag, 32'(n), 32'd4);
  endtask

  task automatic start(input logic [8:0] x, input logic [8:0] y,
                       input logic [15:0] fg, input logic [15:0] bg);
    x_start = x; y_start = y; fg_color = fg; bg_color = bg;
    show_pic_flag = 1'b1;
    tick();
    show_pic_flag = 1'b0;
    // scramble inputs so any failure to latch shows up in the stream
    x_start = 9'h1FF; y_start = 9'h000; fg_color = 16'h1234; bg_color = 16'hABCD;
  endtask

  initial begin
    sys_rst_n = 1'b0; show_pic_flag = 1'b1; wr_done = 1'b0;
    x_start = 9'd0; y_start = 9'd0; fg_color = 16'h0; bg_color = 16'h0;
    repeat (3) tick();
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_data", 32'(show_pic_data), 32'd0);
    check("rst_en", 32'(en_write_show_pic), 32'd0);
    check("rst_done", 32'(show_pic_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    show_pic_flag = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    repeat (4) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_en", 32'(en_write_show_pic), 32'd0);

    // Frame 1: full window + pixel stream
    start(9'd10, 9'd300, 16'hF800, 16'h001F);
    check("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 11; i++) consume(3, $sformatf("win%0d", i), win1[i]);
    check("row0_addr", 32'(rom_addr), 32'd5);
    check("row0_busy", 32'(busy), 32'd1);
    count_fetch("row0_fetch_len");
    for (int i = 0; i < 8; i++) begin
      if (i == 2) show_pic_flag = 1'b1;
      consume(1 + (i % 2), $sformatf("r0_px%0d", i), pix_r0[i]);
      show_pic_flag = 1'b0;
    end
    check("row1_addr", 32'(rom_addr), 32'd6);
    count_fetch("row1_fetch_len");
    for (int i = 0; i < 8; i++) consume(2 - (i % 2), $sformatf("r1_px%0d", i), pix_r1[i]);
    check("done_pulse", 32'(show_pic_done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_en", 32'(en_write_show_pic), 32'd0);
    show_pic_flag = 1'b1;  // arrives in DONE, must be ignored
    tick();
    show_pic_flag = 1'b0;
    check("done_clear", 32'(show_pic_done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_restart_en", 32'(en_write_show_pic), 32'd0);

    // Frame 2: new origin/colours, abort by reset mid-row
    start(9'd0, 9'd0, 16'h07E0, 16'hFFFF);
    for (int i = 0; i < 11; i++) consume(1, $sformatf("w2_%0d", i), win2[i]);
    check("f2_addr", 32'(rom_addr), 32'd5);
    for (int i = 0; i < 3; i++) consume(1, $sformatf("f2_px%0d", i), pix_f2[i]);
    check("f2_busy_mid", 32'(busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en", 32'(en_write_show_pic), 32'd0);
    check("abort_data", 32'(show_pic_data), 32'd0);
    check("abort_addr", 32'(rom_addr), 32'd0);
    tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check("after_abort_busy", 32'(busy), 32'd0);
    check("after_abort_en", 32'(en_write_show_pic), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
